awg_param_ctrl: RTL and testbench

- User-control stage directly upstream of the waveform generator.
- Turns four raw, bouncy, active-low push-buttons into the registered buses the generator consumes: waveform select, frequency word, amplitude code and phase offset.
- Provides debounce, press-edge detection, auto-repeat on the adjust keys, and a field-select state machine.
- Includes a mute function that drives the generator's zero-output code.

---
 rtl/awg_pkg.sv | 38 +++
 rtl/key_debounce.sv | 66 ++++++
 rtl/awg_param_ctrl.sv | 130 +++++++++++++
 tb/tb_awg_param_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// awg_pkg: shared encodings and limits for the AWG user-control stage.
//   sel_e      : field selected for adjustment (drives the LED indicator)
//   wave_e     : waveform codes understood by the generator
//   MUTE_CODE  : generator code that produces zero output
//   next_sel() : cyclic field advance, PHASE wraps back to WAVE
package awg_pkg;

  localparam int unsigned WAVE_W  = 5;
  localparam int unsigned FREQ_W  = 12;
  localparam int unsigned AMP_W   = 3;
  localparam int unsigned PHASE_W = 8;

  typedef enum logic [1:0] {
    SEL_WAVE  = 2'd0,
    SEL_FREQ  = 2'd1,
    SEL_AMP   = 2'd2,
    SEL_PHASE = 2'd3
  } sel_e;

  typedef enum logic [WAVE_W-1:0] {
    WAVE_SAW   = 5'd0,
    WAVE_TRI   = 5'd1,
    WAVE_SQR   = 5'd2,
    WAVE_SIN   = 5'd3,
    WAVE_NOISE = 5'd4
  } wave_e;

  localparam logic [WAVE_W-1:0]  MUTE_CODE = 5'd10;
  localparam logic [FREQ_W-1:0]  FREQ_MAX  = 12'd4095;
  localparam logic [AMP_W-1:0]   AMP_MIN   = 3'd0;
  localparam logic [AMP_W-1:0]   AMP_MAX   = 3'd7;
  localparam logic [AMP_W-1:0]   AMP_RESET = 3'd7;

  function automatic sel_e next_sel(input sel_e s);
    return sel_e'(2'(s) + 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: conditions one raw active-low push-button.
//   clk, rst   : system clock, synchronous active-high reset
//   key_n_i    : raw asynchronous button level (low = pressed)
//   pressed_o  : accepted (debounced) pressed level
//   evt_o      : one-cycle pulse on accepted press, plus auto-repeat
//                pulses while held when REPEAT_EN is set
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
  parameter logic [24:0] REPEAT_PERIOD   = 25'd5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic pressed_o,
  output logic evt_o
);

  logic        sync1_q, sync2_q;
  logic        acc_n_q;
  logic [19:0] cnt_q;
  logic [24:0] hold_q;
  logic        evt_q;

  // Synchronizer, debounce run counter, press pulse and hold/repeat timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_n_q <= 1'b1;
      cnt_q   <= 20'd0;
      hold_q  <= 25'd0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      evt_q   <= 1'b0;

      // Count consecutive samples of a level different from the accepted one.
      if (sync2_q == acc_n_q) begin
        cnt_q <= 20'd0;
      end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        cnt_q   <= 20'd0;
        acc_n_q <= sync2_q;
        evt_q   <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end

      // Reload to DELAY-PERIOD after each repeat so later pulses come every PERIOD.
      if (!REPEAT_EN || acc_n_q) begin
        hold_q <= 25'd0;
      end else if (hold_q == REPEAT_DELAY - 25'd1) begin
        hold_q <= REPEAT_DELAY - REPEAT_PERIOD;
        evt_q  <= 1'b1;
      end else begin
        hold_q <= hold_q + 25'd1;
      end
    end
  end

  assign pressed_o = ~acc_n_q;
  assign evt_o     = evt_q;

endmodule

// File: rtl/awg_param_ctrl.sv
// awg_param_ctrl: push-button front panel for the waveform generator.
//   clk, rst        : system clock, synchronous active-high reset
//   key_*_n         : raw active-low buttons (sel, up, down, mute)
//   state           : waveform code to generator (MUTE_CODE while muted)
//   state_freq      : frequency word, saturating FREQ_MIN..4095
//   state_amp       : amplitude code, saturating 0..7
//   state_phase     : phase offset, wraps modulo 256
//   sel_field       : field currently targeted by up/down
//   muted           : mute flag
module awg_param_ctrl
  import awg_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
  parameter logic [24:0] REPEAT_PERIOD   = 25'd5000000,
  parameter logic [4:0]  MAX_WAVE        = 5'd4,
  parameter logic [11:0] FREQ_MIN        = 12'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_sel_n,
  input  logic               key_up_n,
  input  logic               key_down_n,
  input  logic               key_mute_n,
  output logic [WAVE_W-1:0]  state,
  output logic [FREQ_W-1:0]  state_freq,
  output logic [AMP_W-1:0]   state_amp,
  output logic [PHASE_W-1:0] state_phase,
  output logic [1:0]         sel_field,
  output logic               muted
);

  logic sel_evt, up_evt, dn_evt, mute_evt;
  logic [3:0] pressed_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
                 .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_sel  (.clk(clk), .rst(rst), .key_n_i(key_sel_n),
                .pressed_o(pressed_unused[3]), .evt_o(sel_evt));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                 .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_up   (.clk(clk), .rst(rst), .key_n_i(key_up_n),
                .pressed_o(pressed_unused[2]), .evt_o(up_evt));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                 .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_down (.clk(clk), .rst(rst), .key_n_i(key_down_n),
                .pressed_o(pressed_unused[1]), .evt_o(dn_evt));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
                 .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_mute (.clk(clk), .rst(rst), .key_n_i(key_mute_n),
                .pressed_o(pressed_unused[0]), .evt_o(mute_evt));

  sel_e               sel_q;
  logic [WAVE_W-1:0]  wave_q, wave_d, state_q;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               muted_q, muted_d;
  logic               adj_up_c, adj_dn_c;

  // Opposing adjust keys in the same cycle cancel out.
  assign adj_up_c = up_evt & ~dn_evt;
  assign adj_dn_c = dn_evt & ~up_evt;

  // Adjust targets the field held in sel_q, i.e. before any same-cycle sel advance.
  always_comb begin
    wave_d  = wave_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    phase_d = phase_q;
    muted_d = muted_q ^ mute_evt;
    case (sel_q)
      SEL_WAVE: begin
        if (adj_up_c)
          wave_d = (wave_q >= MAX_WAVE) ? 5'd0 : wave_q + 5'd1;
        else if (adj_dn_c)
          wave_d = (wave_q == 5'd0 || wave_q > MAX_WAVE) ? MAX_WAVE : wave_q - 5'd1;
      end
      SEL_FREQ: begin
        if (adj_up_c)
          freq_d = (freq_q == FREQ_MAX) ? freq_q : freq_q + 12'd1;
        else if (adj_dn_c)
          freq_d = (freq_q <= FREQ_MIN) ? FREQ_MIN : freq_q - 12'd1;
      end
      SEL_AMP: begin
        if (adj_up_c)
          amp_d = (amp_q == AMP_MAX) ? amp_q : amp_q + 3'd1;
        else if (adj_dn_c)
          amp_d = (amp_q == AMP_MIN) ? amp_q : amp_q - 3'd1;
      end
      SEL_PHASE: begin
        if (adj_up_c)
          phase_d = phase_q + 8'd1;
        else if (adj_dn_c)
          phase_d = phase_q - 8'd1;
      end
    endcase
  end

  // Field FSM and registered output buses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= SEL_WAVE;
      wave_q  <= WAVE_SAW;
      state_q <= WAVE_SAW;
      freq_q  <= FREQ_MIN;
      amp_q   <= AMP_RESET;
      phase_q <= 8'd0;
      muted_q <= 1'b0;
    end else begin
      if (sel_evt)
        sel_q <= next_sel(sel_q);
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      phase_q <= phase_d;
      muted_q <= muted_d;
      // Stored wave survives mute; the generator only sees the mute code.
      state_q <= muted_d ? MUTE_CODE : wave_d;
    end
  end

  assign state       = state_q;
  assign state_freq  = freq_q;
  assign state_amp   = amp_q;
  assign state_phase = phase_q;
  assign sel_field   = sel_q;
  assign muted       = muted_q;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// tb_awg_param_ctrl: self-checking bench for awg_param_ctrl with short
// debounce/repeat timing (DEBOUNCE=4, DELAY=16, PERIOD=8).
module tb_awg_param_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_sel_n = 1'b1, key_up_n = 1'b1, key_down_n = 1'b1, key_mute_n = 1'b1;
  logic [4:0]  state;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic [1:0]  sel_field;
  logic        muted;

  awg_param_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .REPEAT_DELAY(25'd16),
    .REPEAT_PERIOD(25'd8),
    .MAX_WAVE(5'd4),
    .FREQ_MIN(12'd1)
  ) dut (
    .clk(clk), .rst(rst),
    .key_sel_n(key_sel_n), .key_up_n(key_up_n),
    .key_down_n(key_down_n), .key_mute_n(key_mute_n),
    .state(state), .state_freq(state_freq), .state_amp(state_amp),
    .state_phase(state_phase), .sel_field(sel_field), .muted(muted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  st;
    logic [11:0] freq;
    logic [2:0]  amp;
    logic [7:0]  phase;
    logic [1:0]  sel;
    logic        mute;
  } obs_t;

  typedef struct {
    logic [3:0] keys;  // {sel, up, down, mute}, 1 = pressed
    obs_t       exp;
  } vec_t;

  localparam logic [3:0] KS = 4'b1000, KU = 4'b0100, KD = 4'b0010, KM = 4'b0001;
  localparam int NVEC = 27;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb_q[$];
  vec_t tbl[NVEC];

  function automatic obs_t mk_obs(input int st, input int f, input int a,
                                  input int p, input int s, input int m);
    return {5'(st), 12'(f), 3'(a), 8'(p), 2'(s), 1'(m)};
  endfunction

  function automatic vec_t mk(input logic [3:0] k, input int st, input int f,
                              input int a, input int p, input int s, input int m);
    vec_t v;
    v.keys = k;
    v.exp  = mk_obs(st, f, a, p, s, m);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_keys(input logic [3:0] m);
    key_sel_n  = ~m[3];
    key_up_n   = ~m[2];
    key_down_n = ~m[1];
    key_mute_n = ~m[0];
  endtask

  task automatic check_obs(input string nm, input obs_t exp);
    obs_t got;
    got = {state, state_freq, state_amp, state_phase, sel_field, muted};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d f=%0d a=%0d p=%0d sel=%0d mute=%0d, expected st=%0d f=%0d a=%0d p=%0d sel=%0d mute=%0d",
               nm, got.st, got.freq, got.amp, got.phase, got.sel, got.mute,
               exp.st, exp.freq, exp.amp, exp.phase, exp.sel, exp.mute);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Short press: accepted after 6 edges, released well before auto-repeat.
  task automatic tap(input logic [3:0] m);
    drive_keys(m);
    tick(10);
    drive_keys(4'b0000);
    tick(10);
  endtask

  // Expected count of events k edges after a held key goes low:
  // press output at edge 7, repeats 16 cycles later then every 8.
  function automatic int n_events(input int k);
    if (k < 7)  return 0;
    if (k < 23) return 1;
    return 2 + (k - 23) / 8;
  endfunction

  initial begin
    bit found;

    tbl[0]  = mk(KU,      2, 1, 7,   0, 0, 0);
    tbl[1]  = mk(KU,      3, 1, 7,   0, 0, 0);
    tbl[2]  = mk(KU,      4, 1, 7,   0, 0, 0);
    tbl[3]  = mk(KU,      0, 1, 7,   0, 0, 0);
    tbl[4]  = mk(KD,      4, 1, 7,   0, 0, 0);
    tbl[5]  = mk(KU,      0, 1, 7,   0, 0, 0);
    tbl[6]  = mk(KU,      1, 1, 7,   0, 0, 0);
    tbl[7]  = mk(KU,      2, 1, 7,   0, 0, 0);
    tbl[8]  = mk(KM,     10, 1, 7,   0, 0, 1);
    tbl[9]  = mk(KU,     10, 1, 7,   0, 0, 1);
    tbl[10] = mk(KM,      3, 1, 7,   0, 0, 0);
    tbl[11] = mk(KU | KD, 3, 1, 7,   0, 0, 0);
    tbl[12] = mk(KS,      3, 1, 7,   0, 1, 0);
    tbl[13] = mk(KD,      3, 1, 7,   0, 1, 0);
    tbl[14] = mk(KU,      3, 2, 7,   0, 1, 0);
    tbl[15] = mk(KU | KS, 3, 3, 7,   0, 2, 0);
    tbl[16] = mk(KU,      3, 3, 7,   0, 2, 0);
    tbl[17] = mk(KD,      3, 3, 6,   0, 2, 0);
    tbl[18] = mk(KU | KM,10, 3, 7,   0, 2, 1);
    tbl[19] = mk(KM,      3, 3, 7,   0, 2, 0);
    tbl[20] = mk(KS,      3, 3, 7,   0, 3, 0);
    tbl[21] = mk(KD,      3, 3, 7, 255, 3, 0);
    tbl[22] = mk(KU,      3, 3, 7,   0, 3, 0);
    tbl[23] = mk(KS,      3, 3, 7,   0, 0, 0);
    tbl[24] = mk(KD,      2, 3, 7,   0, 0, 0);
    tbl[25] = mk(KS | KD, 1, 3, 7,   0, 1, 0);
    tbl[26] = mk(KS | KU, 1, 4, 7,   0, 2, 0);

    // Reset values
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check_obs("reset", mk_obs(0, 1, 7, 0, 0, 0));

    // Bounce then hold on key_up: L H L H (2 cycles each), then held low
    for (int i = 0; i < 4; i++) begin
      key_up_n = (i % 2 == 1);
      tick(2);
    end
    key_up_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k <= 7)
        check_int($sformatf("bounce_k%0d", k), int'(state), (k == 7) ? 1 : 0);
    end
    key_up_n = 1'b1;
    tick(12);
    check_int("no_release_event", int'(state), 1);

    // Table-driven presses through the scoreboard
    for (int i = 0; i < NVEC; i++) begin
      drive_keys(tbl[i].keys);
      sb_q.push_back(tbl[i].exp);
      tick(10);
      drive_keys(4'b0000);
      tick(10);
      check_obs($sformatf("vec%0d", i), sb_q.pop_front());
    end

    // Amp floor: long hold of down in SEL_AMP
    drive_keys(KD);
    tick(80);
    drive_keys(4'b0000);
    tick(10);
    check_obs("amp_floor", mk_obs(1, 4, 0, 0, 2, 0));

    // Auto-repeat timing observed on the phase field
    tap(KS);
    drive_keys(KU);
    for (int k = 1; k <= 47; k++) begin
      tick(1);
      check_int($sformatf("repeat_phase_k%0d", k), int'(state_phase), n_events(k));
    end
    drive_keys(4'b0000);
    tick(10);
    check_obs("repeat_done", mk_obs(1, 4, 0, 5, 3, 0));

    // Freq floor with auto-repeat down
    tap(KS);
    tap(KS);
    drive_keys(KD);
    tick(40);
    drive_keys(4'b0000);
    tick(10);
    check_obs("freq_floor", mk_obs(1, 1, 0, 5, 1, 0));

    // Climb to 4093 with auto-repeat, bounded wait
    drive_keys(KU);
    found = 1'b0;
    for (int c = 0; c < 40000 && !found; c++) begin
      tick(1);
      if (state_freq == 12'd4093) found = 1'b1;
    end
    drive_keys(4'b0000);
    check_int("climb_reached", int'(found), 1);
    tick(10);
    check_obs("freq_4093", mk_obs(1, 4093, 0, 5, 1, 0));
    tap(KU);
    check_obs("freq_4094", mk_obs(1, 4094, 0, 5, 1, 0));

    // Hold up from 4094: reaches 4095 and stays through repeats
    drive_keys(KU);
    for (int k = 1; k <= 47; k++) begin
      tick(1);
      check_int($sformatf("freq_ceiling_k%0d", k), int'(state_freq), (k < 7) ? 4094 : 4095);
    end
    drive_keys(4'b0000);
    tick(10);

    // Mute, then reset mid-hold with key_up still held
    tap(KM);
    check_obs("mute_before_rst", mk_obs(10, 4095, 0, 5, 1, 1));
    drive_keys(KU);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_obs("reset_mid_hold", mk_obs(0, 1, 7, 0, 0, 0));
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check_int($sformatf("post_rst_k%0d", k), int'(state), (k == 7) ? 1 : 0);
    end
    drive_keys(4'b0000);
    tick(10);
    check_obs("post_rst_final", mk_obs(1, 1, 7, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
